dma_sample_packer: RTL

DMA_SAMPLE_PACKER -- requirements
Module: dma_sample_packer

---
 rtl/dma_sample_packer_if.sv | 25 ++
 rtl/dma_sample_packer.sv | 101 ++++++++++
 2 files changed

// File: rtl/dma_sample_packer_if.sv
// Sample-in / packed-word-out signal bundle for dma_sample_packer.
// The slave modport is the packer's view; master is the producer/DMA side.
interface dma_sample_packer_if #(
  parameter int DEPTH = 32
) ();
  logic                     capture_en_i;
  logic [15:0]              sample_i;
  logic                     sample_valid_i;
  logic [63:0]              word_o;
  logic                     word_valid_o;
  logic                     word_ready_i;
  logic                     burst_avail_o;
  logic [$clog2(DEPTH):0]   level_o;
  logic                     overflow_o;

  modport slave (
    input  capture_en_i, sample_i, sample_valid_i, word_ready_i,
    output word_o, word_valid_o, burst_avail_o, level_o, overflow_o
  );

  modport master (
    output capture_en_i, sample_i, sample_valid_i, word_ready_i,
    input  word_o, word_valid_o, burst_avail_o, level_o, overflow_o
  );
endinterface

// File: rtl/dma_sample_packer.sv
// Packs four 16-bit samples into a 64-bit word and queues the words in a
// first-word-fall-through FIFO drained by a DMA engine in bursts.
module dma_sample_packer #(
  parameter int DEPTH     = 32,
  parameter int BURST_LEN = 16
) (
  input  logic                 aclk,
  input  logic                 rst_ni,
  dma_sample_packer_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [1:0]    lane;
  logic [47:0]   part;
  logic          cap_q;
  logic          overflow;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic [63:0]   mem [DEPTH];

  logic          accept;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          word_valid;
  logic          full;
  logic [63:0]   full_word;

  always_comb begin
    accept     = bus.capture_en_i & bus.sample_valid_i;
    push_req   = accept && (lane == 2'd3);
    word_valid = (level != '0);
    pop        = word_valid & bus.word_ready_i;
    full       = (level == LW'(DEPTH));
    // A full FIFO still takes the word if the head leaves in the same cycle.
    push       = push_req && (!full || pop);
    full_word  = {bus.sample_i, part};
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge aclk or negedge rst_ni) begin
    if (!rst_ni) begin
      lane     <= 2'd0;
      part     <= '0;
      cap_q    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      cap_q <= bus.capture_en_i;
      if (!bus.capture_en_i) begin
        lane <= 2'd0;
      end else if (bus.sample_valid_i) begin
        case (lane)
          2'd0:    part[15:0]  <= bus.sample_i;
          2'd1:    part[31:16] <= bus.sample_i;
          2'd2:    part[47:32] <= bus.sample_i;
          default: ;
        endcase
        lane <= lane + 2'd1;
      end
      // Dropping a word outranks the re-arm clear.
      if (push_req && !push) begin
        overflow <= 1'b1;
      end else if (bus.capture_en_i && !cap_q) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage is not reset; entries are only observable once the level
  // counter says they were written, and reset clears that counter.
  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr] <= full_word;
  end

  assign bus.word_o        = word_valid ? mem[rd_ptr] : 64'h0;
  assign bus.word_valid_o  = word_valid;
  assign bus.level_o       = level;
  assign bus.burst_avail_o = (level >= LW'(BURST_LEN));
  assign bus.overflow_o    = overflow;

endmodule
